// File: rtl/ball_move_sched_if.sv
// Keycode/frame-tick/ball-geometry inputs and step-command/status outputs of the
// ball motion scheduler, grouped so the ball datapath side binds them as one bundle.
interface ball_move_sched_if;
    logic [7:0] keycode;
    logic       frame_tick;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       step_valid;
    logic [9:0] step_dx;
    logic [9:0] step_dy;
    logic [1:0] Direction;
    logic       moving;
    logic [1:0] q_count;
    logic       drop_err;

    modport master (
        output keycode, frame_tick, BallX, BallY, BallS,
        input  step_valid, step_dx, step_dy, Direction, moving, q_count, drop_err
    );

    modport slave (
        input  keycode, frame_tick, BallX, BallY, BallS,
        output step_valid, step_dx, step_dy, Direction, moving, q_count, drop_err
    );
endinterface

// File: rtl/ball_move_sched.sv
// Frame-rate motion scheduler: queues filtered direction requests from keycodes and
// issues one wall-checked signed step per frame tick to the ball position register.
module ball_move_sched #(
    parameter logic [9:0] X_MIN = 10'd145,
    parameter logic [9:0] X_MAX = 10'd495,
    parameter logic [9:0] Y_MIN = 10'd65,
    parameter logic [9:0] Y_MAX = 10'd415,
    parameter logic [3:0] STEP  = 4'd1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    ball_move_sched_if.slave        bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MOVE    = 2'b01,
        ST_BLOCKED = 2'b10
    } state_t;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    // Returns {valid, heading} for the four steering keys.
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        logic [2:0] res;
        case (code)
            8'h04:   res = {1'b1, DIR_LEFT};
            8'h07:   res = {1'b1, DIR_RIGHT};
            8'h16:   res = {1'b1, DIR_DOWN};
            8'h1A:   res = {1'b1, DIR_UP};
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    state_t     state_r, state_nx_s;
    logic [7:0] key_prev_r;
    logic [1:0] q_mem_r [2];
    logic [1:0] q_cnt_r;
    logic [1:0] dir_r;
    logic       step_valid_r;
    logic [9:0] step_dx_r;
    logic [9:0] step_dy_r;
    logic       moving_r;
    logic       drop_err_r;

    logic [2:0] key_dec_s;
    logic       req_s;
    logic [1:0] req_dir_s;
    logic [1:0] ref_dir_s;
    logic       accept_s;
    logic       pop_s;
    logic       drop_s;
    logic [1:0] new_dir_s;
    logic       eval_s;
    logic       blocked_s;
    logic [1:0] q0_nx_s, q1_nx_s, q_cnt_nx_s;
    logic       step_valid_nx_s;
    logic [9:0] step_dx_nx_s, step_dy_nx_s;
    logic       moving_nx_s;

    // Widened by one bit beyond the 11-bit sums so no operand combination can wrap.
    logic [11:0] ball_x_s, ball_y_s, ball_s_s, step_s;
    logic [11:0] lim_left_s, lim_up_s, far_right_s, far_down_s;

    // Request filtering against the queue tail (or current heading) and queue pop decision.
    always_comb begin
        key_dec_s = decode_key(bus.keycode);
        req_dir_s = key_dec_s[1:0];
        req_s     = key_dec_s[2] && (bus.keycode != key_prev_r);
        case (q_cnt_r)
            2'd1:    ref_dir_s = q_mem_r[0];
            2'd2:    ref_dir_s = q_mem_r[1];
            default: ref_dir_s = dir_r;
        endcase
        accept_s  = req_s && (req_dir_s != ref_dir_s) && (req_dir_s != (ref_dir_s ^ 2'b01));
        pop_s     = bus.frame_tick && (q_cnt_r != 2'd0);
        drop_s    = accept_s && (q_cnt_r == 2'd2) && !pop_s;
        new_dir_s = pop_s ? q_mem_r[0] : dir_r;
        eval_s    = bus.frame_tick && ((state_r != ST_IDLE) || pop_s);
    end

    // Wall check for the heading that will be in force after this frame's pop.
    always_comb begin
        ball_x_s    = {2'b00, bus.BallX};
        ball_y_s    = {2'b00, bus.BallY};
        ball_s_s    = {2'b00, bus.BallS};
        step_s      = {8'h00, STEP};
        lim_left_s  = {2'b00, X_MIN} + ball_s_s + step_s;
        lim_up_s    = {2'b00, Y_MIN} + ball_s_s + step_s;
        far_right_s = ball_x_s + ball_s_s + step_s;
        far_down_s  = ball_y_s + ball_s_s + step_s;
        case (new_dir_s)
            DIR_LEFT:  blocked_s = (ball_x_s < lim_left_s);
            DIR_RIGHT: blocked_s = (far_right_s > {2'b00, X_MAX});
            DIR_DOWN:  blocked_s = (far_down_s > {2'b00, Y_MAX});
            DIR_UP:    blocked_s = (ball_y_s < lim_up_s);
            default:   blocked_s = 1'b1;
        endcase
    end

    // Turn-queue next contents; head lives in slot 0.
    always_comb begin
        q0_nx_s    = q_mem_r[0];
        q1_nx_s    = q_mem_r[1];
        q_cnt_nx_s = q_cnt_r;
        case ({pop_s, accept_s})
            2'b11: begin
                if (q_cnt_r == 2'd1) begin
                    q0_nx_s = req_dir_s;
                end else begin
                    q0_nx_s = q_mem_r[1];
                    q1_nx_s = req_dir_s;
                end
            end
            2'b10: begin
                q0_nx_s    = q_mem_r[1];
                q_cnt_nx_s = q_cnt_r - 2'd1;
            end
            2'b01: begin
                if (q_cnt_r == 2'd0) begin
                    q0_nx_s    = req_dir_s;
                    q_cnt_nx_s = 2'd1;
                end else if (q_cnt_r == 2'd1) begin
                    q1_nx_s    = req_dir_s;
                    q_cnt_nx_s = 2'd2;
                end else begin
                    q_cnt_nx_s = q_cnt_r;
                end
            end
            default: q_cnt_nx_s = q_cnt_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: only a frame tick that evaluates a heading moves the machine.
    always_comb begin
        state_nx_s = state_r;
        if (eval_s) begin
            state_nx_s = blocked_s ? ST_BLOCKED : ST_MOVE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM outputs: step command for the heading just evaluated.
    always_comb begin
        step_valid_nx_s = eval_s && !blocked_s;
        step_dx_nx_s    = 10'd0;
        step_dy_nx_s    = 10'd0;
        moving_nx_s     = (state_nx_s == ST_MOVE);
        if (step_valid_nx_s) begin
            case (new_dir_s)
                DIR_LEFT:  step_dx_nx_s = 10'd0 - {6'd0, STEP};
                DIR_RIGHT: step_dx_nx_s = {6'd0, STEP};
                DIR_DOWN:  step_dy_nx_s = {6'd0, STEP};
                DIR_UP:    step_dy_nx_s = 10'd0 - {6'd0, STEP};
                default:   step_dx_nx_s = 10'd0;
            endcase
        end else begin
            step_dx_nx_s = 10'd0;
        end
    end

    // Key history, queue, heading and registered step/status outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            key_prev_r   <= 8'h00;
            q_mem_r[0]   <= 2'b00;
            q_mem_r[1]   <= 2'b00;
            q_cnt_r      <= 2'd0;
            dir_r        <= DIR_LEFT;
            step_valid_r <= 1'b0;
            step_dx_r    <= 10'd0;
            step_dy_r    <= 10'd0;
            moving_r     <= 1'b0;
            drop_err_r   <= 1'b0;
        end else begin
            key_prev_r   <= bus.keycode;
            q_mem_r[0]   <= q0_nx_s;
            q_mem_r[1]   <= q1_nx_s;
            q_cnt_r      <= q_cnt_nx_s;
            dir_r        <= new_dir_s;
            step_valid_r <= step_valid_nx_s;
            step_dx_r    <= step_dx_nx_s;
            step_dy_r    <= step_dy_nx_s;
            moving_r     <= moving_nx_s;
            drop_err_r   <= drop_err_r | drop_s;
        end
    end

    assign bus.step_valid = step_valid_r;
    assign bus.step_dx    = step_dx_r;
    assign bus.step_dy    = step_dy_r;
    assign bus.Direction  = dir_r;
    assign bus.moving     = moving_r;
    assign bus.q_count    = q_cnt_r;
    assign bus.drop_err   = drop_err_r;
endmodule

// File: tb/tb_ball_move_sched.sv
// Randomized bench for ball_move_sched against a queue-based behavioural model of the
// request filter, turn queue, frame scheduler and wall checks.
module tb_ball_move_sched;
    localparam int XMIN = 145;
    localparam int XMAX = 495;
    localparam int YMIN = 65;
    localparam int YMAX = 415;
    localparam int STP  = 1;

    logic Clk = 1'b0;
    logic Reset;
    ball_move_sched_if bus();

    ball_move_sched dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state: 0 idle, 1 moving, 2 blocked
    int         m_state;
    bit [1:0]   m_dir;
    bit [1:0]   mq[$];
    bit [7:0]   m_kprev;
    bit         m_drop;
    bit         e_sv;
    bit [9:0]   e_dx, e_dy;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_dir   = 2'd0;
        mq.delete();
        m_kprev = 8'h00;
        m_drop  = 1'b0;
        e_sv    = 1'b0;
        e_dx    = 10'd0;
        e_dy    = 10'd0;
    endtask

    function automatic bit key_dir(input bit [7:0] kc, output bit [1:0] d);
        d = 2'd0;
        if (kc == 8'h04) begin d = 2'd0; return 1'b1; end
        if (kc == 8'h07) begin d = 2'd1; return 1'b1; end
        if (kc == 8'h16) begin d = 2'd2; return 1'b1; end
        if (kc == 8'h1A) begin d = 2'd3; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic bit wall_blocked(input bit [1:0] d, input int bx, input int by, input int bs);
        case (d)
            2'd0:    return bx < XMIN + bs + STP;
            2'd1:    return bx + bs + STP > XMAX;
            2'd2:    return by + bs + STP > YMAX;
            default: return by < YMIN + bs + STP;
        endcase
    endfunction

    task automatic model_step(input bit [7:0] kc, input bit ft, input int bx, input int by, input int bs);
        bit [1:0] d, rf;
        bit req, acc, pop;
        req = (kc != m_kprev) && key_dir(kc, d);
        m_kprev = kc;
        rf  = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
        acc = req && (d != rf) && (d != (rf ^ 2'b01));
        pop = ft && (mq.size() > 0);
        e_sv = 1'b0;
        e_dx = 10'd0;
        e_dy = 10'd0;
        if (pop) m_dir = mq.pop_front();
        if (ft && (m_state != 0 || pop)) begin
            if (wall_blocked(m_dir, bx, by, bs)) begin
                m_state = 2;
            end else begin
                m_state = 1;
                e_sv = 1'b1;
                case (m_dir)
                    2'd0:    e_dx = 10'(-STP);
                    2'd1:    e_dx = 10'(STP);
                    2'd2:    e_dy = 10'(STP);
                    default: e_dy = 10'(-STP);
                endcase
            end
        end
        if (acc) begin
            if (mq.size() < 2) mq.push_back(d);
            else m_drop = 1'b1;
        end
    endtask

    task automatic check_outputs(input string phase);
        check_eq({phase, ".step_valid"}, bus.step_valid, e_sv);
        check_eq({phase, ".step_dx"},    bus.step_dx,    e_dx);
        check_eq({phase, ".step_dy"},    bus.step_dy,    e_dy);
        check_eq({phase, ".Direction"},  bus.Direction,  m_dir);
        check_eq({phase, ".moving"},     bus.moving,     (m_state == 1) ? 1 : 0);
        check_eq({phase, ".q_count"},    bus.q_count,    mq.size());
        check_eq({phase, ".drop_err"},   bus.drop_err,   m_drop);
    endtask

    task automatic do_cycle(input string phase, input bit [7:0] kc, input bit ft,
                            input int bx, input int by, input int bs);
        bus.keycode    = kc;
        bus.frame_tick = ft;
        bus.BallX      = 10'(bx);
        bus.BallY      = 10'(by);
        bus.BallS      = 10'(bs);
        model_step(kc, ft, bx, by, bs);
        @(posedge Clk);
        #1;
        check_outputs(phase);
    endtask

    initial begin
        bit [7:0] kc;
        bit       ft;
        int       hold, gap, bx, by, bs;

        Reset          = 1'b0;
        bus.keycode    = 8'h00;
        bus.frame_tick = 1'b0;
        bus.BallX      = 10'd320;
        bus.BallY      = 10'd240;
        bus.BallS      = 10'd8;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_outputs("reset");
        Reset = 1'b1;

        // steer down from the reset heading, then a tick in open field
        do_cycle("first_key", 8'h16, 1'b0, 416, 240, 8);
        do_cycle("first_key", 8'h16, 1'b0, 416, 240, 8);
        do_cycle("first_tick", 8'h16, 1'b1, 416, 240, 8);
        do_cycle("idle_gap", 8'h00, 1'b0, 416, 240, 8);
        // reverse (up) rejected while heading down
        do_cycle("reverse", 8'h1A, 1'b0, 416, 240, 8);
        do_cycle("reverse", 8'h00, 1'b1, 416, 240, 8);
        // right, then turn into the right wall
        do_cycle("right", 8'h07, 1'b0, 416, 240, 8);
        do_cycle("right", 8'h00, 1'b1, 487, 240, 8);
        do_cycle("blocked", 8'h00, 1'b0, 487, 240, 8);
        do_cycle("blocked", 8'h00, 1'b1, 486, 240, 8);
        do_cycle("unblock", 8'h16, 1'b0, 486, 240, 8);
        do_cycle("unblock", 8'h16, 1'b1, 486, 240, 8);
        // three accepted presses with no tick overflow the queue
        do_cycle("fill", 8'h07, 1'b0, 320, 240, 8);
        do_cycle("fill", 8'h00, 1'b0, 320, 240, 8);
        do_cycle("fill", 8'h16, 1'b0, 320, 240, 8);
        do_cycle("fill", 8'h00, 1'b0, 320, 240, 8);
        do_cycle("fill", 8'h04, 1'b0, 320, 240, 8);
        check_eq("drop_err_set", bus.drop_err, 1);
        do_cycle("drain", 8'h00, 1'b1, 320, 240, 8);
        do_cycle("drain", 8'h00, 1'b0, 320, 240, 8);
        do_cycle("drain", 8'h00, 1'b1, 320, 240, 8);
        check_eq("drop_err_sticky", bus.drop_err, 1);

        // reset arriving while a step command is on the outputs
        do_cycle("pre_rst", 8'h07, 1'b0, 320, 240, 8);
        do_cycle("pre_rst", 8'h00, 1'b1, 320, 240, 8);
        bus.keycode = 8'h00;
        #1 Reset = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        @(posedge Clk);
        #1 Reset = 1'b1;
        do_cycle("post_rst", 8'h00, 1'b1, 320, 240, 8);

        // randomized traffic
        hold = 0;
        gap  = 0;
        kc   = 8'h00;
        bx   = 320; by = 240; bs = 8;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 6))
                    0, 5:    kc = 8'h00;
                    1:       kc = 8'h04;
                    2:       kc = 8'h07;
                    3:       kc = 8'h16;
                    4:       kc = 8'h1A;
                    default: kc = 8'($urandom);
                endcase
                hold = $urandom_range(1, 6);
            end
            hold--;
            ft = 1'b0;
            if (gap > 0) begin
                gap--;
            end else if ($urandom_range(0, 2) == 0) begin
                ft  = 1'b1;
                gap = 1;
            end
            if (!ft && $urandom_range(0, 15) == 0) begin
                bs = $urandom_range(0, 24);
                bx = $urandom_range(130, 510);
                by = $urandom_range(50, 430);
            end
            do_cycle("random", kc, ft, bx, by, bs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
